// File: rtl/fft_for_ofdm_pkg.sv
// Shared definitions for the OFDM QPSK mapper + 16-point FFT core.
// Contents: word-size parameters, Q8.8 constants, the W16 twiddle tables,
// the FSM state type and a 4-bit bit-reverse helper.
package fft_for_ofdm_pkg;

  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned DATA_LENGTH = 8;
  localparam int unsigned FRACTION    = 8;
  localparam int unsigned STAGES      = 4;
  localparam int unsigned N_POINTS    = 16;
  localparam int unsigned N_BFLY      = N_POINTS / 2;

  // Q8.8: 1.0 = 256
  localparam logic signed [WORD_SIZE-1:0] ONE     = 16'sd256;
  localparam logic signed [WORD_SIZE-1:0] NEG_ONE = -16'sd256;

  // W16^k = cos - j*sin, k = 0..7
  localparam logic signed [WORD_SIZE-1:0] TW_COS [N_BFLY] = '{
    16'sd256, 16'sd237, 16'sd181, 16'sd98, 16'sd0, -16'sd98, -16'sd181, -16'sd237
  };
  localparam logic signed [WORD_SIZE-1:0] TW_SIN [N_BFLY] = '{
    16'sd0, 16'sd98, 16'sd181, 16'sd237, 16'sd256, 16'sd237, 16'sd181, 16'sd98
  };

  typedef enum logic {StLoad, StCalc} state_t;

  function automatic logic [3:0] bit_reverse(input logic [3:0] idx);
    return {idx[0], idx[1], idx[2], idx[3]};
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: y0 = a + W*b, y1 = a - W*b.
// Ports: a_re/a_im, b_re/b_im  - input operands (Q8.8)
//        tw_cos/tw_sin         - twiddle W = tw_cos - j*tw_sin (Q8.8)
//        y0_re/y0_im, y1_re/y1_im - outputs, wrapping modulo 2^WORD_SIZE
module fft_butterfly
  import fft_for_ofdm_pkg::*;
(
  input  logic signed [WORD_SIZE-1:0] a_re,
  input  logic signed [WORD_SIZE-1:0] a_im,
  input  logic signed [WORD_SIZE-1:0] b_re,
  input  logic signed [WORD_SIZE-1:0] b_im,
  input  logic signed [WORD_SIZE-1:0] tw_cos,
  input  logic signed [WORD_SIZE-1:0] tw_sin,
  output logic signed [WORD_SIZE-1:0] y0_re,
  output logic signed [WORD_SIZE-1:0] y0_im,
  output logic signed [WORD_SIZE-1:0] y1_re,
  output logic signed [WORD_SIZE-1:0] y1_im
);

  logic signed [31:0] p_cr, p_si, p_ci, p_sr;
  logic signed [31:0] sum_re, sum_im, sh_re, sh_im;
  logic signed [WORD_SIZE-1:0] wb_re, wb_im;

  always_comb begin
    // (c - js)(br + j bi) = (c*br + s*bi) + j(c*bi - s*br)
    p_cr   = tw_cos * b_re;
    p_si   = tw_sin * b_im;
    p_ci   = tw_cos * b_im;
    p_sr   = tw_sin * b_re;
    sum_re = p_cr + p_si;
    sum_im = p_ci - p_sr;
    // Arithmetic shift floors toward -inf, then truncate to the word
    sh_re  = sum_re >>> FRACTION;
    sh_im  = sum_im >>> FRACTION;
    wb_re  = sh_re[WORD_SIZE-1:0];
    wb_im  = sh_im[WORD_SIZE-1:0];
    y0_re  = a_re + wb_re;
    y0_im  = a_im + wb_im;
    y1_re  = a_re - wb_re;
    y1_im  = a_im - wb_im;
  end

endmodule

// File: rtl/fft_for_ofdm.sv
// OFDM baseband core: packs 4 bytes into 16 QPSK symbols, then runs an iterative
// 16-point radix-2 DIT FFT, one stage per clock. Frame period is 8 cycles.
// Ports: i_clk            - clock, rising edge
//        i_rst            - synchronous active-high reset
//        i_byte           - payload byte, sampled during the 4 load cycles
//        outK_re/outK_im  - registered bin K of the last completed FFT (K = 0..15)
//        o_FFT_cycle_done - one-cycle pulse when the out* registers update
module fft_for_ofdm
  import fft_for_ofdm_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_LENGTH-1:0] i_byte,
  output logic [WORD_SIZE-1:0]   out0_re,  output logic [WORD_SIZE-1:0] out0_im,
  output logic [WORD_SIZE-1:0]   out1_re,  output logic [WORD_SIZE-1:0] out1_im,
  output logic [WORD_SIZE-1:0]   out2_re,  output logic [WORD_SIZE-1:0] out2_im,
  output logic [WORD_SIZE-1:0]   out3_re,  output logic [WORD_SIZE-1:0] out3_im,
  output logic [WORD_SIZE-1:0]   out4_re,  output logic [WORD_SIZE-1:0] out4_im,
  output logic [WORD_SIZE-1:0]   out5_re,  output logic [WORD_SIZE-1:0] out5_im,
  output logic [WORD_SIZE-1:0]   out6_re,  output logic [WORD_SIZE-1:0] out6_im,
  output logic [WORD_SIZE-1:0]   out7_re,  output logic [WORD_SIZE-1:0] out7_im,
  output logic [WORD_SIZE-1:0]   out8_re,  output logic [WORD_SIZE-1:0] out8_im,
  output logic [WORD_SIZE-1:0]   out9_re,  output logic [WORD_SIZE-1:0] out9_im,
  output logic [WORD_SIZE-1:0]   out10_re, output logic [WORD_SIZE-1:0] out10_im,
  output logic [WORD_SIZE-1:0]   out11_re, output logic [WORD_SIZE-1:0] out11_im,
  output logic [WORD_SIZE-1:0]   out12_re, output logic [WORD_SIZE-1:0] out12_im,
  output logic [WORD_SIZE-1:0]   out13_re, output logic [WORD_SIZE-1:0] out13_im,
  output logic [WORD_SIZE-1:0]   out14_re, output logic [WORD_SIZE-1:0] out14_im,
  output logic [WORD_SIZE-1:0]   out15_re, output logic [WORD_SIZE-1:0] out15_im,
  output logic                   o_FFT_cycle_done
);

  state_t                      state_q;
  logic [1:0]                  load_cnt_q;
  logic [1:0]                  stage_cnt_q;
  logic                        done_q;
  logic signed [WORD_SIZE-1:0] work_re_q [N_POINTS];
  logic signed [WORD_SIZE-1:0] work_im_q [N_POINTS];
  logic signed [WORD_SIZE-1:0] out_re_q  [N_POINTS];
  logic signed [WORD_SIZE-1:0] out_im_q  [N_POINTS];

  // Butterfly addressing for the current stage
  logic [3:0] span, mask;
  logic [3:0] top_idx [N_BFLY];
  logic [3:0] bot_idx [N_BFLY];
  logic [3:0] tw_full [N_BFLY];
  logic [2:0] tw_idx  [N_BFLY];

  always_comb begin
    span = 4'd1 << stage_cnt_q;
    mask = span - 4'd1;
    for (int b = 0; b < N_BFLY; b++) begin
      // Butterfly b sits in group b>>s at offset b mod 2^s; groups are 2^(s+1) wide
      top_idx[b] = ((4'(b) & ~mask) << 1) | (4'(b) & mask);
      bot_idx[b] = top_idx[b] + span;
      tw_full[b] = (4'(b) & mask) << (2'd3 - stage_cnt_q);
      tw_idx[b]  = tw_full[b][2:0];
    end
  end

  logic signed [WORD_SIZE-1:0] bf_y0_re [N_BFLY];
  logic signed [WORD_SIZE-1:0] bf_y0_im [N_BFLY];
  logic signed [WORD_SIZE-1:0] bf_y1_re [N_BFLY];
  logic signed [WORD_SIZE-1:0] bf_y1_im [N_BFLY];

  for (genvar g = 0; g < N_BFLY; g++) begin : g_bfly
    fft_butterfly u_bfly (
      .a_re   (work_re_q[top_idx[g]]),
      .a_im   (work_im_q[top_idx[g]]),
      .b_re   (work_re_q[bot_idx[g]]),
      .b_im   (work_im_q[bot_idx[g]]),
      .tw_cos (TW_COS[tw_idx[g]]),
      .tw_sin (TW_SIN[tw_idx[g]]),
      .y0_re  (bf_y0_re[g]),
      .y0_im  (bf_y0_im[g]),
      .y1_re  (bf_y1_re[g]),
      .y1_im  (bf_y1_im[g])
    );
  end

  // Working array after the current stage
  logic signed [WORD_SIZE-1:0] calc_re [N_POINTS];
  logic signed [WORD_SIZE-1:0] calc_im [N_POINTS];

  always_comb begin
    for (int i = 0; i < N_POINTS; i++) begin
      calc_re[i] = work_re_q[i];
      calc_im[i] = work_im_q[i];
    end
    for (int b = 0; b < N_BFLY; b++) begin
      calc_re[top_idx[b]] = bf_y0_re[b];
      calc_im[top_idx[b]] = bf_y0_im[b];
      calc_re[bot_idx[b]] = bf_y1_re[b];
      calc_im[bot_idx[b]] = bf_y1_im[b];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StLoad;
      load_cnt_q  <= 2'd0;
      stage_cnt_q <= 2'd0;
      done_q      <= 1'b0;
      for (int i = 0; i < N_POINTS; i++) begin
        work_re_q[i] <= '0;
        work_im_q[i] <= '0;
        out_re_q[i]  <= '0;
        out_im_q[i]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StLoad: begin
          // Symbol n = 4k+m from bits [2m+1:2m]; stored bit-reversed for DIT
          for (int m = 0; m < 4; m++) begin
            work_re_q[bit_reverse({load_cnt_q, 2'(m)})] <= i_byte[2*m]   ? NEG_ONE : ONE;
            work_im_q[bit_reverse({load_cnt_q, 2'(m)})] <= i_byte[2*m+1] ? NEG_ONE : ONE;
          end
          load_cnt_q <= load_cnt_q + 2'd1;
          if (load_cnt_q == 2'd3) begin
            state_q     <= StCalc;
            stage_cnt_q <= 2'd0;
          end
        end
        StCalc: begin
          for (int i = 0; i < N_POINTS; i++) begin
            work_re_q[i] <= calc_re[i];
            work_im_q[i] <= calc_im[i];
          end
          stage_cnt_q <= stage_cnt_q + 2'd1;
          if (stage_cnt_q == 2'(STAGES - 1)) begin
            for (int i = 0; i < N_POINTS; i++) begin
              out_re_q[i] <= calc_re[i];
              out_im_q[i] <= calc_im[i];
            end
            done_q     <= 1'b1;
            state_q    <= StLoad;
            load_cnt_q <= 2'd0;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign o_FFT_cycle_done = done_q;

  assign out0_re  = out_re_q[0];   assign out0_im  = out_im_q[0];
  assign out1_re  = out_re_q[1];   assign out1_im  = out_im_q[1];
  assign out2_re  = out_re_q[2];   assign out2_im  = out_im_q[2];
  assign out3_re  = out_re_q[3];   assign out3_im  = out_im_q[3];
  assign out4_re  = out_re_q[4];   assign out4_im  = out_im_q[4];
  assign out5_re  = out_re_q[5];   assign out5_im  = out_im_q[5];
  assign out6_re  = out_re_q[6];   assign out6_im  = out_im_q[6];
  assign out7_re  = out_re_q[7];   assign out7_im  = out_im_q[7];
  assign out8_re  = out_re_q[8];   assign out8_im  = out_im_q[8];
  assign out9_re  = out_re_q[9];   assign out9_im  = out_im_q[9];
  assign out10_re = out_re_q[10];  assign out10_im = out_im_q[10];
  assign out11_re = out_re_q[11];  assign out11_im = out_im_q[11];
  assign out12_re = out_re_q[12];  assign out12_im = out_im_q[12];
  assign out13_re = out_re_q[13];  assign out13_im = out_im_q[13];
  assign out14_re = out_re_q[14];  assign out14_im = out_im_q[14];
  assign out15_re = out_re_q[15];  assign out15_im = out_im_q[15];

endmodule

// File: tb/tb_fft_for_ofdm.sv
// Scoreboard bench for fft_for_ofdm: frames push expected bins and due cycle,
// a negedge monitor pops and compares whenever the done strobe is seen.
module tb_fft_for_ofdm;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic [15:0] o_re [16];
  logic [15:0] o_im [16];
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] exp_q [$];
  int          due_q [$];

  int twc [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int tws [8] = '{0, 98, 181, 237, 256, 237, 181, 98};
  shortint m_re [16];
  shortint m_im [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_for_ofdm dut (
    .i_clk(clk), .i_rst(rst), .i_byte(byte_in),
    .out0_re(o_re[0]),   .out0_im(o_im[0]),   .out1_re(o_re[1]),   .out1_im(o_im[1]),
    .out2_re(o_re[2]),   .out2_im(o_im[2]),   .out3_re(o_re[3]),   .out3_im(o_im[3]),
    .out4_re(o_re[4]),   .out4_im(o_im[4]),   .out5_re(o_re[5]),   .out5_im(o_im[5]),
    .out6_re(o_re[6]),   .out6_im(o_im[6]),   .out7_re(o_re[7]),   .out7_im(o_im[7]),
    .out8_re(o_re[8]),   .out8_im(o_im[8]),   .out9_re(o_re[9]),   .out9_im(o_im[9]),
    .out10_re(o_re[10]), .out10_im(o_im[10]), .out11_re(o_re[11]), .out11_im(o_im[11]),
    .out12_re(o_re[12]), .out12_im(o_im[12]), .out13_re(o_re[13]), .out13_im(o_im[13]),
    .out14_re(o_re[14]), .out14_im(o_im[14]), .out15_re(o_re[15]), .out15_im(o_im[15]),
    .o_FFT_cycle_done(done)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Textbook in-place DIT FFT in Q8.8 with the quantised twiddle table
  task automatic model(input logic [31:0] w);
    logic [3:0] n4, r;
    logic [1:0] bits;
    int half, t, a, b, pr, pi;
    shortint wr, wi, ar, ai;
    for (int n = 0; n < 16; n++) begin
      bits = w[8*(n/4) + 2*(n%4) +: 2];
      n4   = 4'(n);
      r    = {n4[0], n4[1], n4[2], n4[3]};
      m_re[r] = bits[0] ? -16'sd256 : 16'sd256;
      m_im[r] = bits[1] ? -16'sd256 : 16'sd256;
    end
    for (int s = 0; s < 4; s++) begin
      half = 1 << s;
      for (int start = 0; start < 16; start += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          t  = j * (16 / (2 * half));
          a  = start + j;
          b  = a + half;
          pr = twc[t] * int'(m_re[b]) + tws[t] * int'(m_im[b]);
          pi = twc[t] * int'(m_im[b]) - tws[t] * int'(m_re[b]);
          wr = shortint'(pr >>> 8);
          wi = shortint'(pi >>> 8);
          ar = m_re[a];
          ai = m_im[a];
          m_re[a] = shortint'(ar + wr);
          m_im[a] = shortint'(ai + wi);
          m_re[b] = shortint'(ar - wr);
          m_im[b] = shortint'(ai - wi);
        end
      end
    end
  endtask

  // use_model=0: all bins zero except bin `bin` = (re, im)
  task automatic run_frame(input logic [31:0] w, input bit use_model, input int bin,
                           input logic [15:0] re, input logic [15:0] im);
    for (int k = 0; k < 4; k++) begin
      byte_in = w[8*k +: 8];
      @(posedge clk); #1;
    end
    if (use_model) model(w);
    for (int k = 0; k < 16; k++) exp_q.push_back(use_model ? 16'(m_re[k]) : (k == bin ? re : 16'h0));
    for (int k = 0; k < 16; k++) exp_q.push_back(use_model ? 16'(m_im[k]) : (k == bin ? im : 16'h0));
    due_q.push_back(cyc + 4);
    for (int k = 0; k < 4; k++) begin
      byte_in = 8'($urandom);  // ignored during CALC
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_done"}, int'(done), 0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_bin%0d_re", tag, k), int'(o_re[k]), 0);
      check($sformatf("%s_bin%0d_im", tag, k), int'(o_im[k]), 0);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (due_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        check("done_cycle", cyc, due_q.pop_front());
        for (int k = 0; k < 16; k++)
          check($sformatf("bin%0d_re", k), int'(o_re[k]), int'(exp_q.pop_front()));
        for (int k = 0; k < 16; k++)
          check($sformatf("bin%0d_im", k), int'(o_im[k]), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    run_frame(32'h0000_0000, 1'b0, 0, 16'h1000, 16'h1000);
    run_frame(32'hFFFF_FFFF, 1'b0, 0, 16'hF000, 16'hF000);
    run_frame(32'h5555_5555, 1'b0, 0, 16'hF000, 16'h1000);
    run_frame(32'hCCCC_CCCC, 1'b0, 8, 16'h1000, 16'h1000);
    run_frame(32'h0100_0000, 1'b1, 0, 16'h0, 16'h0);
    for (int f = 0; f < 12; f++) run_frame($urandom, 1'b1, 0, 16'h0, 16'h0);

    // Reset during CALC: partial frame dropped, outputs cleared, no done
    for (int k = 0; k < 6; k++) begin
      byte_in = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midcalc_reset");
    rst = 1'b0;
    for (int f = 0; f < 3; f++) run_frame($urandom, 1'b1, 0, 16'h0, 16'h0);

    @(negedge clk); #1;
    check("queue_drain", due_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
